// File: rtl/trace_pkg.sv
// trace_pkg: shared state encodings and default widths for the trace capture slice.
package trace_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;
  localparam int TIMESTAMP_WIDTH = 40;
  localparam int DEF_DATA_WIDTH  = 120;
  localparam int DEF_ADDR_WIDTH  = 8;
endpackage

// File: rtl/trace_masked_cmp.sv
// trace_masked_cmp: masked equality compare; an all-zero mask always hits.
module trace_masked_cmp #(
  parameter int DATA_WIDTH = trace_pkg::DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  hit
);
  assign hit = (data & mask) == (value & mask);
endmodule

// File: rtl/trace_trigger_ctl.sv
// trace_trigger_ctl: filters events into a trace array, detects a counted trigger,
// then captures a programmed number of post-trigger pushes before freezing the array.
module trace_trigger_ctl
  import trace_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int POST_WIDTH = 16,
  parameter int OCC_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] cfg_cap_mask,
  input  logic [DATA_WIDTH-1:0] cfg_cap_value,
  input  logic [DATA_WIDTH-1:0] cfg_trig_mask,
  input  logic [DATA_WIDTH-1:0] cfg_trig_value,
  input  logic [OCC_WIDTH-1:0]  cfg_trig_count,
  input  logic [POST_WIDTH-1:0] cfg_post_count,
  input  logic                  event_valid,
  input  logic [0:DATA_WIDTH-1] event_data,
  output logic                  trace_valid,
  output logic [0:DATA_WIDTH-1] trace_data,
  output logic                  local_trace_stop,
  output logic [1:0]            trig_state,
  output logic                  triggered,
  output logic [ADDR_WIDTH-1:0] trig_index
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cap_mask_q, cap_value_q, trig_mask_q, trig_value_q;
  logic [OCC_WIDTH-1:0]  trig_count_q, occ_q, occ_d, occ_inc, thr;
  logic [POST_WIDTH-1:0] post_count_q, post_q, post_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, tidx_q, tidx_d;
  logic                  trig_q, trig_d, tv_q, stop_q;
  logic [0:DATA_WIDTH-1] td_q;
  logic                  cap_cmp, trig_cmp, cap_hit, trig_hit, arm_ok, fire, push;

  trace_masked_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cap_cmp (
    .data(event_data), .mask(cap_mask_q), .value(cap_value_q), .hit(cap_cmp)
  );
  trace_masked_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_trig_cmp (
    .data(event_data), .mask(trig_mask_q), .value(trig_value_q), .hit(trig_cmp)
  );

  assign cap_hit  = event_valid & cap_cmp;
  assign trig_hit = event_valid & trig_cmp;
  assign arm_ok   = arm & ~disarm & (state_q == ST_IDLE || state_q == ST_DONE);
  assign thr      = (trig_count_q == '0) ? OCC_WIDTH'(1) : trig_count_q;
  assign occ_inc  = (occ_q == '1) ? occ_q : occ_q + 1'b1;
  assign fire     = force_trig | (trig_hit & (occ_inc == thr));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    occ_d   = occ_q;
    post_d  = post_q;
    trig_d  = trig_q;
    tidx_d  = tidx_q;
    push    = 1'b0;
    if (disarm) state_d = ST_IDLE;
    else if (arm_ok) begin
      state_d = ST_ARMED;
      idx_d   = '0;
      occ_d   = '0;
      trig_d  = 1'b0;
    end else if (state_q == ST_ARMED) begin
      // the triggering event is always recorded, even if the capture filter rejects it
      push = fire ? event_valid : cap_hit;
      if (trig_hit) occ_d = occ_inc;
      if (fire) begin
        tidx_d  = idx_q;
        trig_d  = 1'b1;
        post_d  = post_count_q;
        state_d = (post_count_q != '0) ? ST_POST : ST_DONE;
      end
    end else if (state_q == ST_POST && cap_hit) begin
      push    = 1'b1;
      post_d  = (post_q != '0) ? post_q - 1'b1 : post_q;
      state_d = (post_q <= POST_WIDTH'(1)) ? ST_DONE : ST_POST;
    end
    if (push) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      occ_q        <= '0;
      post_q       <= '0;
      trig_q       <= 1'b0;
      tidx_q       <= '0;
      tv_q         <= 1'b0;
      td_q         <= '0;
      stop_q       <= 1'b0;
      cap_mask_q   <= '0;
      cap_value_q  <= '0;
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      trig_count_q <= '0;
      post_count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      occ_q   <= occ_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
      tidx_q  <= tidx_d;
      tv_q    <= push;
      td_q    <= push ? event_data : td_q;
      stop_q  <= state_d == ST_DONE;
      if (arm_ok) begin
        cap_mask_q   <= cfg_cap_mask;
        cap_value_q  <= cfg_cap_value;
        trig_mask_q  <= cfg_trig_mask;
        trig_value_q <= cfg_trig_value;
        trig_count_q <= cfg_trig_count;
        post_count_q <= cfg_post_count;
      end
    end
  end

  assign trace_valid      = tv_q;
  assign trace_data       = td_q;
  assign local_trace_stop = stop_q;
  assign trig_state       = state_q;
  assign triggered        = trig_q;
  assign trig_index       = tidx_q;
endmodule
